// File: rtl/explode_scheduler.sv
// explode_scheduler: arbitrates two tanks' hit requests and sequences a shared explosion animation
module explode_scheduler #(
  parameter int FRAME_TICKS = 6,
  parameter int NUM_FRAMES  = 11
) (
  input  logic       frame_clk,
  input  logic       Reset_n,
  input  logic       hit1,
  input  logic       hit2,
  output logic       anim_active,
  output logic       anim_owner,
  output logic [3:0] explode_frame,
  output logic       done1,
  output logic       done2,
  output logic [1:0] pend
);
  localparam logic [1:0] S_IDLE = 2'd0, S_PLAY = 2'd1, S_DONE = 2'd2;
  logic [1:0] r_state, w_next;
  logic [1:0] r_hit_q, r_pend;
  logic [3:0] r_frame;
  logic [7:0] r_tick;
  logic       r_owner, r_last;
  logic [1:0] w_edge, w_own_mask, w_req;
  logic       w_grant_ok, w_grantee, w_wrap, w_last_frame;
  assign w_edge       = {hit2, hit1} & ~r_hit_q;
  assign w_own_mask   = r_owner ? 2'b10 : 2'b01;
  // the finishing owner's own edge during DONE is not a request
  assign w_req        = (r_state == S_DONE) ? (r_pend | (w_edge & ~w_own_mask)) : (r_pend | w_edge);
  assign w_grant_ok   = (r_state != S_PLAY) && (|w_req);
  // on a tie the tank that did not win last time goes first
  assign w_grantee    = (&w_req) ? ~r_last : w_req[1];
  assign w_wrap       = r_tick == 8'(FRAME_TICKS - 1);
  assign w_last_frame = w_wrap && (r_frame == 4'(NUM_FRAMES));
  // state register
  always_ff @(posedge frame_clk or negedge Reset_n)
    if (!Reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  // next-state: PLAY runs to the final frame wrap, otherwise a pending or fresh request starts PLAY
  always_comb
    w_next = (r_state == S_PLAY) ? (w_last_frame ? S_DONE : S_PLAY) : (w_grant_ok ? S_PLAY : S_IDLE);
  // outputs decoded from state
  always_comb begin
    anim_active = r_state == S_PLAY;
    done1       = (r_state == S_DONE) && !r_owner;
    done2       = (r_state == S_DONE) && r_owner;
  end
  // frame/tick counters, ownership and pending requests
  always_ff @(posedge frame_clk or negedge Reset_n)
    if (!Reset_n) begin
      r_hit_q <= 2'b00;
      r_pend  <= 2'b00;
      r_frame <= 4'd0;
      r_tick  <= 8'd0;
      r_owner <= 1'b0;
      r_last  <= 1'b1;
    end else begin
      r_hit_q <= {hit2, hit1};
      if (w_grant_ok) begin
        r_frame <= 4'd1;
        r_tick  <= 8'd0;
        r_owner <= w_grantee;
        r_last  <= w_grantee;
        r_pend  <= w_req & ~(w_grantee ? 2'b10 : 2'b01);
      end else if (r_state == S_PLAY) begin
        r_tick  <= w_wrap ? 8'd0 : r_tick + 8'd1;
        r_frame <= w_last_frame ? 4'd0 : (w_wrap ? r_frame + 4'd1 : r_frame);
        r_pend  <= r_pend | (w_edge & ~w_own_mask);
      end else begin
        r_frame <= 4'd0;
      end
    end
  assign anim_owner    = r_owner;
  assign explode_frame = r_frame;
  assign pend          = r_pend;
endmodule

// File: doc/explode_scheduler.md
EXPLODE_SCHEDULER -- requirements
Module: explode_scheduler

Interface
REQ-001 Parameter FRAME_TICKS, default 6, frame_clk cycles each animation frame is held; legal range 1..255.
REQ-002 Parameter NUM_FRAMES, default 11, number of animation frames per explosion; legal range 1..15.
REQ-003 Port frame_clk  in  1  sole clock; all state updates on its rising edge.
REQ-004 Port Reset_n  in  1  asynchronous, active-low reset.
REQ-005 Port hit1  in  1  tank1 bullet-collide level; a rising edge requests an explosion.
REQ-006 Port hit2  in  1  tank2 bullet-collide level; a rising edge requests an explosion.
REQ-007 Port anim_active  out  1  high while an explosion is playing.
REQ-008 Port anim_owner  out  1  0 = tank1, 1 = tank2; owner of the current or most recent explosion.
REQ-009 Port explode_frame  out  4  current frame index; 0 = no explosion, 1..NUM_FRAMES = playing.
REQ-010 Port done1, done2  out  1 each  one-cycle pulse when that tank's explosion completes.
REQ-011 Port pend  out  2  bit0/bit1 = tank1/tank2 request waiting for service.

Function
REQ-012 The block SHALL register hit1/hit2 each cycle (hit_q); an edge is hitN & ~hitN_q.
REQ-013 The FSM SHALL have exactly three states: IDLE, PLAY, DONE.
REQ-014 In IDLE, an edge or a set pend bit SHALL grant: next state PLAY, explode_frame=1, tick counter=0, anim_owner=grantee, grantee pend bit cleared.
REQ-015 Latency: explode_frame SHALL read 1 in the cycle after the clock edge that samples the hit rising edge in IDLE.
REQ-016 In PLAY the tick counter SHALL increment each cycle; at FRAME_TICKS-1 it SHALL wrap to 0 and explode_frame SHALL increment.
REQ-017 Each frame value SHALL be held exactly FRAME_TICKS cycles; PLAY SHALL last exactly NUM_FRAMES*FRAME_TICKS cycles.
REQ-018 When the tick counter wraps with explode_frame==NUM_FRAMES, the next state SHALL be DONE.
REQ-019 In DONE (exactly one cycle): explode_frame=0, anim_active=0, and done1 or done2 (per anim_owner) SHALL be 1.
REQ-020 From DONE: if any pend bit or edge is present, the next state SHALL be PLAY with the REQ-014 grant; otherwise IDLE.
REQ-021 In PLAY or DONE, an edge from the non-owner SHALL set its pend bit; an edge from the current owner SHALL be ignored.
REQ-022 Tie (both tanks eligible in the same grant cycle): grant the tank != last_owner; last_owner updates on every grant.
REQ-023 An edge arriving while that tank's pend bit is already set SHALL be absorbed; there is no queue depth beyond 1 per tank.
REQ-024 A hit level held high SHALL NOT retrigger; only a new 0->1 transition requests.
REQ-025 anim_active SHALL equal (state==PLAY); outputs SHALL be registered or decoded from state only.

Reset
REQ-026 On Reset_n low, the block SHALL immediately set: state IDLE, explode_frame 0, tick 0, anim_active 0, anim_owner 0, done1/done2 0, pend 00, hit_q 00, last_owner 1.
REQ-027 Reset mid-PLAY SHALL abort the animation with no done pulse.
REQ-028 A hit held high across reset release SHALL count as an edge on the first clock edge after release.

Verification (FRAME_TICKS=2, NUM_FRAMES=3)
REQ-029 Single hit1 pulse in IDLE -> explode_frame 1,1,2,2,3,3 then 0 with done1=1 for 1 cycle; anim_owner=0; then IDLE.
REQ-030 hit1 and hit2 rise on the same cycle after reset -> tank1 plays first (pend=10 during play), DONE 1 cycle, tank2 plays immediately; done1 then done2.
REQ-031 hit2 rises during tank1 frame 2 -> pend[1]=1; tank2 animation starts on the cycle after tank1's DONE.
REQ-032 hit1 toggles 0->1->0->1 during its own PLAY -> no pend bit set, exactly 6 PLAY cycles, one done1.
REQ-033 Reset_n asserted during frame 2 -> explode_frame 0 and anim_active 0 asynchronously, no done pulse; with hit1 still high at release -> new tank1 animation starts.
REQ-034 hit2 held high for 20 cycles -> exactly one animation and one done2.
